// File: rtl/alu_pkg.sv
// Shared definitions for the execute unit: ALU operation codes,
// mul/div operation enumeration and the mul/div engine state type.
package alu_pkg;

   localparam logic [4:0] ALU_AND = 5'b00000;
   localparam logic [4:0] ALU_OR  = 5'b00001;
   localparam logic [4:0] ALU_ADD = 5'b00010;
   localparam logic [4:0] ALU_SUB = 5'b00110;
   localparam logic [4:0] ALU_SLT = 5'b00111;
   localparam logic [4:0] ALU_NOR = 5'b01100;
   localparam logic [4:0] ALU_XOR = 5'b01101;
   localparam logic [4:0] ALU_SLL = 5'b10000;
   localparam logic [4:0] ALU_SRL = 5'b11000;
   localparam logic [4:0] ALU_SRA = 5'b11001;

   typedef enum logic [2:0] {
      MD_NONE  = 3'd0,
      MD_MULT  = 3'd1,
      MD_MULTU = 3'd2,
      MD_DIV   = 3'd3,
      MD_DIVU  = 3'd4,
      MD_MTHI  = 3'd5,
      MD_MTLO  = 3'd6
   } md_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIN  = 2'd2
   } md_state_e;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide engine owning the HI/LO registers.
// Ports: clk, reset (sync, active-low), in1/in2 operands, md_op/md_start
// command, busy/done handshake, hi/lo architectural registers.
import alu_pkg::*;

module muldiv_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [2:0]       md_op,
   input  logic             md_start,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] LAST = SHW'(WIDTH - 1);

   md_state_e state, state_n;

   logic [SHW-1:0]       cnt;
   logic [2*WIDTH-1:0]   acc;
   logic [WIDTH-1:0]     opd;
   logic                 is_div;
   logic                 neg_lo;
   logic                 neg_hi;
   logic                 dz;

   logic                 accept;
   logic                 launch;
   logic                 wr_hi;
   logic                 wr_lo;
   logic                 div_op;
   logic                 signed_op;
   logic                 a_neg;
   logic                 b_neg;
   logic                 last;
   logic [WIDTH-1:0]     abs1;
   logic [WIDTH-1:0]     abs2;

   logic [WIDTH:0]       mul_sum;
   logic [WIDTH:0]       div_t;
   logic [WIDTH:0]       div_diff;
   logic                 div_ge;
   logic [2*WIDTH-1:0]   acc_n;
   logic [2*WIDTH-1:0]   prod;
   logic [WIDTH-1:0]     quo;
   logic [WIDTH-1:0]     rem;
   logic [WIDTH-1:0]     res_hi;
   logic [WIDTH-1:0]     res_lo;

   // Command decode; FIN accepts a new command just like IDLE.
   always_comb begin
      accept    = md_start && (state != ST_RUN);
      div_op    = (md_op == MD_DIV) || (md_op == MD_DIVU);
      launch    = accept && ((md_op == MD_MULT) || (md_op == MD_MULTU)
                             || div_op);
      wr_hi     = accept && (md_op == MD_MTHI);
      wr_lo     = accept && (md_op == MD_MTLO);
      signed_op = (md_op == MD_MULT) || (md_op == MD_DIV);
      a_neg     = signed_op && in1[WIDTH-1];
      b_neg     = signed_op && in2[WIDTH-1];
      abs1      = a_neg ? -in1 : in1;
      abs2      = b_neg ? -in2 : in2;
      last      = (cnt == LAST);
   end

   // One iteration step. acc holds {upper, lower}: for multiply the
   // partial product and the remaining multiplier bits, for divide the
   // partial remainder and the dividend/quotient shift register.
   always_comb begin
      mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, opd} : '0);
      div_t    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
      div_diff = div_t - {1'b0, opd};
      // The partial remainder stays below the divisor, so the shifted
      // value never reaches 2^WIDTH + divisor; the borrow bit alone
      // tells whether the subtraction fits.
      div_ge   = ~div_diff[WIDTH];
      if (is_div)
         acc_n = {(div_ge ? div_diff[WIDTH-1:0] : div_t[WIDTH-1:0]),
                  acc[WIDTH-2:0], div_ge};
      else
         acc_n = {mul_sum, acc[WIDTH-1:1]};

      prod = neg_lo ? -acc_n : acc_n;
      quo  = acc_n[WIDTH-1:0];
      rem  = acc_n[2*WIDTH-1:WIDTH];
      if (is_div) begin
         // Divide by zero leaves |dividend| as remainder; restoring its
         // sign hands back the original dividend in HI.
         res_lo = dz ? '1 : (neg_lo ? -quo : quo);
         res_hi = neg_hi ? -rem : rem;
      end else begin
         res_lo = prod[WIDTH-1:0];
         res_hi = prod[2*WIDTH-1:WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (!reset)
         state <= ST_IDLE;
      else
         state <= state_n;
   end

   always_comb begin
      state_n = state;
      busy    = 1'b0;
      done    = 1'b0;
      case (state)
         ST_IDLE,
         ST_FIN: state_n = launch ? ST_RUN : ST_IDLE;
         ST_RUN: if (last) state_n = ST_FIN;
         default: state_n = ST_IDLE;
      endcase
      busy = (state == ST_RUN);
      done = (state == ST_FIN);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hi     <= '0;
         lo     <= '0;
         cnt    <= '0;
         acc    <= '0;
         opd    <= '0;
         is_div <= 1'b0;
         neg_lo <= 1'b0;
         neg_hi <= 1'b0;
         dz     <= 1'b0;
      end else begin
         if (launch) begin
            cnt    <= '0;
            is_div <= div_op;
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= a_neg;
            dz     <= div_op && (in2 == '0);
            if (div_op) begin
               opd <= abs2;
               acc <= {{WIDTH{1'b0}}, abs1};
            end else begin
               opd <= abs1;
               acc <= {{WIDTH{1'b0}}, abs2};
            end
         end else if (state == ST_RUN) begin
            acc <= acc_n;
            cnt <= cnt + 1'b1;
            if (last) begin
               hi <= res_hi;
               lo <= res_lo;
            end
         end
         if (wr_hi)
            hi <= in1;
         if (wr_lo)
            lo <= in1;
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// Execute unit: combinational ALU plus the iterative mul/div engine.
// Ports: clk, reset (sync, active-low), in1/in2, alu_ctl, sign -> out/zero;
// md_op/md_start -> busy/done, hi/lo.
import alu_pkg::*;

module alu_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] in2,
   input  logic [4:0]       alu_ctl,
   input  logic             sign,
   input  logic [2:0]       md_op,
   input  logic             md_start,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int SHW = $clog2(WIDTH);

   logic [SHW-1:0] shamt;
   logic           lt;

   assign shamt = in1[SHW-1:0];
   assign lt    = sign ? ($signed(in1) < $signed(in2)) : (in1 < in2);

   always_comb begin
      out = '0;
      case (alu_ctl)
         ALU_AND: out = in1 & in2;
         ALU_OR:  out = in1 | in2;
         ALU_ADD: out = in1 + in2;
         ALU_SUB: out = in1 - in2;
         ALU_SLT: out = {{(WIDTH-1){1'b0}}, lt};
         ALU_NOR: out = ~(in1 | in2);
         ALU_XOR: out = in1 ^ in2;
         ALU_SLL: out = in2 << shamt;
         ALU_SRL: out = in2 >> shamt;
         ALU_SRA: out = $signed(in2) >>> shamt;
         default: out = '0;
      endcase
   end

   assign zero = (out == '0);

   muldiv_seq #(
      .WIDTH(WIDTH)
   ) u_muldiv (
      .clk      (clk),
      .reset    (reset),
      .in1      (in1),
      .in2      (in2),
      .md_op    (md_op),
      .md_start (md_start),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo)
   );

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv (WIDTH=32): ALU reference checks
// plus a HI/LO scoreboard drained by a monitor on every done pulse.
module tb_alu_muldiv;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] in1 = '0;
   logic [31:0] in2 = '0;
   logic [4:0]  alu_ctl = '0;
   logic        sign = 1'b0;
   logic [2:0]  md_op = '0;
   logic        md_start = 1'b0;
   logic [31:0] out;
   logic        zero;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int          errs = 0;
   int          checks = 0;
   int          busy_cnt = 0;
   logic [63:0] exp_q[$];
   logic [63:0] mon_e;

   always #5 clk = ~clk;

   alu_muldiv #(.WIDTH(32)) dut (
      .clk      (clk),
      .reset    (reset),
      .in1      (in1),
      .in2      (in2),
      .alu_ctl  (alu_ctl),
      .sign     (sign),
      .md_op    (md_op),
      .md_start (md_start),
      .out      (out),
      .zero     (zero),
      .busy     (busy),
      .done     (done),
      .hi       (hi),
      .lo       (lo)
   );

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] alu_ref(input logic [4:0] c,
                                           input logic [31:0] a,
                                           input logic [31:0] b,
                                           input logic s);
      logic signed [31:0] sb;
      int                 ia, ib;
      longint             ua, ub;
      sb = b;
      ia = a;
      ib = b;
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      case (c)
         5'b00000: return a & b;
         5'b00001: return a | b;
         5'b00010: return a + b;
         5'b00110: return a - b;
         5'b00111: return (s ? (ia < ib) : (ua < ub)) ? 32'd1 : 32'd0;
         5'b01100: return ~(a | b);
         5'b01101: return a ^ b;
         5'b10000: return b << a[4:0];
         5'b11000: return b >> a[4:0];
         5'b11001: return sb >>> a[4:0];
         default:  return 32'd0;
      endcase
   endfunction

   // Returns {hi, lo}.
   function automatic logic [63:0] md_ref(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
      int          sa, sb, q, r;
      logic [63:0] p;
      sa = a;
      sb = b;
      case (op)
         3'd1: begin
            p = longint'(sa) * longint'(sb);
            return p;
         end
         3'd2: begin
            p = {32'h0, a} * {32'h0, b};
            return p;
         end
         3'd3: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               return {32'h0, 32'h8000_0000};
            q = sa / sb;
            r = sa % sb;
            return {r, q};
         end
         3'd4: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
         default: return 64'h0;
      endcase
   endfunction

   // Scoreboard monitor: busy cycles are counted and every done pulse
   // must match the oldest queued expectation.
   always @(negedge clk) begin
      if (!reset) begin
         busy_cnt = 0;
      end else if (busy) begin
         busy_cnt++;
      end else if (done) begin
         if (exp_q.size() == 0) begin
            check("unexpected_done", 64'd1, 64'd0);
         end else begin
            mon_e = exp_q.pop_front();
            check("md_hi", {32'h0, hi}, {32'h0, mon_e[63:32]});
            check("md_lo", {32'h0, lo}, {32'h0, mon_e[31:0]});
            check("md_busy_cycles", 64'(busy_cnt), 64'd32);
         end
         busy_cnt = 0;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic md_go(input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b);
      md_op    = op;
      in1      = a;
      in2      = b;
      md_start = 1'b1;
      if (op >= 3'd1 && op <= 3'd4)
         exp_q.push_back(md_ref(op, a, b));
      tick();
      md_start = 1'b0;
      md_op    = 3'd0;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (!done && n < 200) begin
         tick();
         n++;
      end
      if (!done)
         check("done_timeout", 64'd0, 64'd1);
   endtask

   task automatic alu_chk(input logic [4:0] c, input logic [31:0] a,
                          input logic [31:0] b, input logic s);
      logic [31:0] e;
      alu_ctl = c;
      in1     = a;
      in2     = b;
      sign    = s;
      #1;
      e = alu_ref(c, a, b, s);
      check($sformatf("alu_out_%b", c), {32'h0, out}, {32'h0, e});
      check("alu_zero", {63'h0, zero}, {63'h0, (e == 32'h0)});
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout");
      $fatal(1);
   end

   initial begin
      logic [4:0]  codes [11];
      logic [2:0]  op;
      logic [31:0] a, b;
      int          n;

      codes = '{5'b00000, 5'b00001, 5'b00010, 5'b00110, 5'b00111,
                5'b01100, 5'b01101, 5'b10000, 5'b11000, 5'b11001,
                5'b00011};

      reset = 1'b0;
      repeat (3) tick();
      check("rst_hi", {32'h0, hi}, 64'h0);
      check("rst_lo", {32'h0, lo}, 64'h0);
      check("rst_busy", {63'h0, busy}, 64'h0);
      check("rst_done", {63'h0, done}, 64'h0);
      reset = 1'b1;
      tick();

      alu_chk(5'b00111, 32'hFFFF_FFFF, 32'd1, 1'b1);
      check("slt_signed", {32'h0, out}, 64'd1);
      alu_chk(5'b00111, 32'hFFFF_FFFF, 32'd1, 1'b0);
      check("slt_unsigned", {32'h0, out}, 64'd0);
      alu_chk(5'b11001, 32'd4, 32'h8000_0000, 1'b0);
      check("sra_plan", {32'h0, out}, 64'hF800_0000);
      alu_chk(5'b10000, 32'd31, 32'h0000_0003, 1'b0);
      alu_chk(5'b11000, 32'hFFFF_FFE0, 32'hDEAD_BEEF, 1'b0);
      alu_chk(5'b00111, 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
      alu_chk(5'b11111, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
      for (int i = 0; i < 150; i++)
         alu_chk(codes[$urandom_range(0, 10)], $urandom, $urandom,
                 1'($urandom_range(0, 1)));

      md_go(3'd1, 32'hFFFF_FFFD, 32'd7);
      check("busy_after_start", {63'h0, busy}, 64'd1);
      wait_done(n);
      check("mult_plan_hi", {32'h0, hi}, 64'hFFFF_FFFF);
      check("mult_plan_lo", {32'h0, lo}, 64'hFFFF_FFEB);
      tick();
      md_go(3'd4, 32'd100, 32'd7);
      wait_done(n);
      tick();
      md_go(3'd3, 32'hFFFF_FFF9, 32'd2);
      wait_done(n);
      tick();
      md_go(3'd4, 32'd5, 32'd0);
      wait_done(n);
      tick();
      md_go(3'd3, 32'hFFFF_FFF9, 32'd0);
      wait_done(n);
      tick();
      md_go(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(n);
      tick();

      md_go(3'd2, 32'hCAFE_F00D, 32'h1357_9BDF);
      repeat (9) tick();
      md_op    = 3'd3;
      in1      = 32'd77;
      in2      = 32'd5;
      md_start = 1'b1;
      tick();
      md_start = 1'b0;
      md_op    = 3'd0;
      wait_done(n);
      tick();

      md_op    = 3'd2;
      in1      = 32'h0BAD_F00D;
      in2      = 32'h0000_1234;
      md_start = 1'b1;
      tick();
      md_start = 1'b0;
      md_op    = 3'd0;
      repeat (9) tick();
      reset = 1'b0;
      tick();
      check("midrst_hi", {32'h0, hi}, 64'h0);
      check("midrst_lo", {32'h0, lo}, 64'h0);
      check("midrst_busy", {63'h0, busy}, 64'h0);
      check("midrst_done", {63'h0, done}, 64'h0);
      reset = 1'b1;
      repeat (40) tick();
      check("midrst_idle", {63'h0, busy}, 64'h0);

      md_go(3'd5, 32'h0000_1234, 32'h0);
      check("mthi_hi", {32'h0, hi}, 64'h1234);
      check("mthi_busy", {63'h0, busy}, 64'h0);
      md_go(3'd6, 32'h0000_ABCD, 32'h0);
      check("mtlo_lo", {32'h0, lo}, 64'hABCD);
      check("mtlo_hi_hold", {32'h0, hi}, 64'h1234);
      check("mtlo_done", {63'h0, done}, 64'h0);

      md_go(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(n);
      md_go(3'd2, 32'h0001_0001, 32'h0002_0003);
      wait_done(n);
      check("b2b_spacing", 64'(n + 1), 64'd33);
      tick();

      for (int i = 0; i < 30; i++) begin
         op = 3'($urandom_range(1, 4));
         a  = $urandom;
         b  = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
         if ($urandom_range(0, 3) == 0)
            b = 32'($urandom_range(1, 9));
         if ($urandom_range(0, 3) == 0)
            b = -b;
         md_go(op, a, b);
         wait_done(n);
         tick();
      end

      tick();
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
Parametrised next-generation execute unit for the MIPS pipeline. It holds the single-cycle combinational ALU path (logic, add/sub, set-less-than, shifts) at generic WIDTH, plus an iterative multiply/divide engine. The engine writes architectural HI/LO registers and drives a busy/done handshake, so hazard logic can stall MFHI/MFLO and back-to-back mul/div.

Parameters:
WIDTH, 32, datapath width in bits; power of two, at least 8
SHW, $clog2(WIDTH), shift-amount width; derived, not overridable

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
in1  in  WIDTH  operand A; also the shift amount (low SHW bits)
in2  in  WIDTH  operand B; also the shifted value
alu_ctl  in  5  combinational ALU operation code
sign  in  1  1 = signed SLT compare
md_op  in  3  mul/div op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO
md_start  in  1  launch md_op (qualified by md_op != 0)
out  out  WIDTH  combinational ALU result
zero  out  1  out == 0
busy  out  1  engine iterating
done  out  1  one-cycle pulse when HI/LO were updated by MULT/DIV
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Combinational path, zero latency, independent of engine state.
- alu_ctl codes: 00000 AND; 00001 OR; 00010 ADD (wrap); 00110 SUB (wrap); 00111 SLT; 01100 NOR; 01101 XOR; 10000 SLL in2 by in1[SHW-1:0]; 11000 SRL; 11001 SRA; any other code gives out = 0.
- SLT: out = {WIDTH-1 zeros, lt}. lt is the true two's-complement compare when sign = 1, unsigned compare otherwise. Operands of opposite sign must compare correctly.
- Reset (reset = 0 at a clock edge): hi = lo = 0, busy = 0, done = 0, engine goes to IDLE. Applies mid-operation: the in-flight op is aborted and no done is produced.
- FSM states: IDLE, RUN, FIN.
  - IDLE: md_start && md_op in 1..4 at edge k latches operands, clears the counter, and enters RUN. busy = 1 from cycle k+1.
  - MTHI/MTLO in IDLE: hi (or lo) <= in1 at edge k; single cycle; no busy, no done.
  - RUN: one iteration per cycle for exactly WIDTH cycles (shift-add multiply; restoring divide), then FIN.
  - FIN: hi/lo written at the edge entering FIN, i.e. edge k+WIDTH+1. done = 1 and busy = 0 during the FIN cycle. FIN returns to IDLE on the next edge.
  - md_start in FIN is accepted as if in IDLE (back-to-back allowed).
- md_start while in RUN: ignored; must not disturb the operation.
- Multiply: 2*WIDTH-bit product; hi = upper WIDTH bits, lo = lower WIDTH bits. MULT is signed; iterate on magnitudes and negate the product if the operand signs differ.
- Divide: lo = quotient, hi = remainder. DIV truncates toward zero; remainder takes the dividend's sign.
- Divide by zero: lo = all ones, hi = dividend; normal WIDTH-cycle latency; no trap.
- DIV of most-negative by -1: lo = most-negative, hi = 0.
- hi/lo hold their values at all other times. Outputs are registered except out and zero.

Decomposition:
- Package alu_pkg: alu_ctl code constants, md_op enumeration, FSM state typedef.
- Sub-module muldiv_seq: operand latch, sign handling, iteration datapath, counter, FSM, HI/LO registers.
- alu_muldiv instantiates muldiv_seq and contains the combinational ALU.

Test Plan:
- WIDTH=32. SLT sign=1, in1=0xFFFFFFFF, in2=1 -> out=1. With sign=0 -> out=0. SRA in2=0x80000000, in1=4 -> out=0xF8000000.
- MULT in1=-3, in2=7 -> busy for cycles k+1..k+32; done at k+33; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIVU 100/7 -> lo=14, hi=2. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5, done after 32 busy cycles. DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
- Start MULTU; assert md_start with DIV at cycle k+10 -> ignored, MULTU result intact. Second run: reset=0 at cycle k+10 -> hi=lo=0, busy=0, no done.
- MTHI in1=0x1234 -> hi=0x1234 next cycle, busy stays 0. Back-to-back MULTU started in the FIN cycle -> second done exactly 33 cycles later.
